// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: fetch PC, per-stage valids, load enables,
// oldest-first flush resolution with bubble-collapsing hold chain, retire order.
// All outputs combinational from state and inputs; state updates on posedge clk.
module pipe_ctrl #(
   parameter int          NSTAGES    = 5,
   parameter logic [31:0] RESET_PC   = 32'h1eceb000,
   parameter int          INSN_BYTES = 4,
   parameter int          ORDER_W    = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NSTAGES-1:0]      stall_req,
   input  logic [NSTAGES-1:0]      flush_req,
   input  logic [32*NSTAGES-1:0]   flush_pc,
   output logic [31:0]             pc,
   output logic                    fetch_kill,
   output logic [NSTAGES-1:0]      stage_valid,
   output logic [NSTAGES-1:0]      load_en,
   output logic [NSTAGES-1:0]      flush_ack,
   output logic                    retire_valid,
   output logic [ORDER_W-1:0]      retire_order
);

   // Registered state; stage 0 is implicitly live whenever out of reset.
   logic [NSTAGES-1:1] v_q;
   logic [31:0]        pc_q;
   logic [ORDER_W-1:0] order_q;

   logic [NSTAGES-1:0] v;
   logic [NSTAGES:0]   hold;

   logic               flush_any;
   logic               flush_blocked;
   logic [NSTAGES-1:0] flush_oh;
   logic [NSTAGES-1:0] kill_mask;
   logic [31:0]        flush_tgt;
   logic               accept;
   logic               retire;

   logic [NSTAGES-1:1] v_d;
   logic [31:0]        pc_d;
   logic [ORDER_W-1:0] order_d;

   assign v = {v_q, ~rst};

   // Hold chain from writeback down: a stage holds only if it is live and
   // either stalls itself or is blocked by a held successor, so bubbles collapse.
   always_comb begin
      hold          = '0;
      hold[NSTAGES] = 1'b0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         hold[k] = v[k] & (stall_req[k] | hold[k+1]);
      end
   end

   // Pick the oldest live redirect; ascending scan so the highest index wins.
   // Stage 0 never redirects, and a held winner blocks all younger requests.
   always_comb begin
      flush_any     = 1'b0;
      flush_blocked = 1'b0;
      flush_oh      = '0;
      kill_mask     = '0;
      flush_tgt     = '0;
      for (int k = 0; k < NSTAGES; k++) begin
         if (flush_req[k] && v[k] && (k != 0)) begin
            flush_any     = 1'b1;
            flush_blocked = hold[k];
            flush_oh      = '0;
            flush_oh[k]   = 1'b1;
            flush_tgt     = flush_pc[32*k +: 32];
            for (int j = 0; j < NSTAGES; j++) begin
               kill_mask[j] = (j <= k);
            end
         end
      end
   end

   assign accept = flush_any & ~flush_blocked & ~rst;
   assign retire = ~rst & v[NSTAGES-1] & ~stall_req[NSTAGES-1];

   // Output drive; everything is forced quiet while reset is asserted.
   always_comb begin
      pc           = pc_q;
      fetch_kill   = accept;
      stage_valid  = rst ? '0 : v;
      load_en      = rst ? '0 : (~hold[NSTAGES-1:0] | (accept ? kill_mask : '0));
      flush_ack    = accept ? flush_oh : '0;
      retire_valid = retire;
      retire_order = order_q;
   end

   // Next-state: advance unheld stages, kill everything younger than an
   // accepted redirect, and steer the PC.
   always_comb begin
      v_d = v_q;
      for (int k = 1; k < NSTAGES; k++) begin
         if (!hold[k]) begin
            v_d[k] = v[k-1] & ~hold[k-1];
         end
         if (accept && kill_mask[k]) begin
            v_d[k] = 1'b0;
         end
      end

      if (accept) begin
         pc_d = flush_tgt;
      end else if (hold[0]) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_q + 32'(INSN_BYTES);
      end

      order_d = order_q + {{(ORDER_W-1){1'b0}}, retire};
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= '0;
         pc_q    <= RESET_PC;
         order_q <= '0;
      end else begin
         v_q     <= v_d;
         pc_q    <= pc_d;
         order_q <= order_d;
      end
   end

endmodule
